// File: rtl/ps2_host_ctrl_pkg.sv
// Shared types and constants for the PS/2 host-to-device command path.
// Used by the controller, its line filter and any bench that drives them.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_TX,
        ST_LINE_ACK,
        ST_ACK_WAIT
    } ps2_state_e;

    localparam logic [7:0] PS2_ACK     = 8'hFA;
    localparam logic [7:0] PS2_RESEND  = 8'hFE;
    localparam logic [7:0] PS2_SET_LED = 8'hED;

    localparam logic [1:0] ERR_NONE        = 2'd0;
    localparam logic [1:0] ERR_BIT_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_NO_LINE_ACK = 2'd2;
    localparam logic [1:0] ERR_NO_ACK      = 2'd3;

    // Bits shifted out after the start bit: data LSB first, odd parity, stop.
    function automatic logic [9:0] ps2_frame(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

endpackage

// File: rtl/ps2_host_ctrl_if.sv
// Command/status bundle between a system-side requester and ps2_host_ctrl.
// cmd_valid/cmd_ready: a command transfers on the cycle both are high; the
// requester holds cmd_valid and payload stable until then, and cmd_ready never
// waits on cmd_valid. done/err are single-cycle pulses; err_code is level.
interface ps2_host_ctrl_if;
    import ps2_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_byte;
    logic       cmd_has_arg;
    logic [7:0] cmd_arg;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    modport master (
        output cmd_valid, cmd_byte, cmd_has_arg, cmd_arg,
        input  cmd_ready, busy, done, err, err_code
    );

    modport slave (
        input  cmd_valid, cmd_byte, cmd_has_arg, cmd_arg,
        output cmd_ready, busy, done, err, err_code
    );

endinterface

// File: rtl/ps2_host_ctrl_line_filter.sv
// Two-flop synchronizer plus 4-sample glitch filter for one PS/2 bus line.
// fall is high for exactly the cycle before the filtered level drops to 0.
module ps2_line_filter (
    input  logic clk_100mhz,
    input  logic rst_n,
    input  logic line,
    output logic level,
    output logic fall
);

    logic       sync1, sync2;
    logic [3:0] samples;

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            samples <= 4'hF;
            level   <= 1'b1;
        end else begin
            sync1   <= line;
            sync2   <= sync1;
            samples <= {samples[2:0], sync2};
            if (samples == 4'hF) level <= 1'b1;
            else if (samples == 4'h0) level <= 1'b0;
        end
    end

    assign fall = level && (samples == 4'h0);

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host-to-device transmitter: inhibit, start, 10 clocked bits, line-ack,
// then waits for the device's ACK/RESEND byte, with optional argument byte.
module ps2_host_ctrl
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC     = 10000,
    parameter int BIT_TIMEOUT_CYC = 200000,
    parameter int ACK_TIMEOUT_CYC = 2000000,
    parameter int MAX_RETRY       = 2
) (
    input  logic              clk_100mhz,
    input  logic              rst_n,
    input  logic              ps2_c,
    input  logic              ps2_d,
    output logic              ps2_c_oe,
    output logic              ps2_d_oe,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              host_tx_active,
    ps2_host_ctrl_if.slave    cmd,
    output ps2_state_e        state_dbg
);

    localparam int TW = $clog2(ACK_TIMEOUT_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] INH_LOAD = TW'(INHIBIT_CYC - 1);
    localparam logic [TW-1:0] BIT_LOAD = TW'(BIT_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] ACK_LOAD = TW'(ACK_TIMEOUT_CYC - 1);

    ps2_state_e    state;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry;
    logic [3:0]    bit_cnt;
    logic [7:0]    tx_byte;
    logic [7:0]    arg_byte;
    logic          arg_pending;
    logic [9:0]    frame;
    logic          c_level, c_fall, d_level, d_fall_unused;

    ps2_line_filter u_c_filt (
        .clk_100mhz (clk_100mhz), .rst_n (rst_n), .line (ps2_c),
        .level (c_level), .fall (c_fall)
    );

    ps2_line_filter u_d_filt (
        .clk_100mhz (clk_100mhz), .rst_n (rst_n), .line (ps2_d),
        .level (d_level), .fall (d_fall_unused)
    );

    assign frame          = ps2_frame(tx_byte);
    assign state_dbg      = state;
    assign cmd.cmd_ready  = (state == ST_IDLE);
    assign cmd.busy       = (state != ST_IDLE);
    assign host_tx_active = (state == ST_INHIBIT) || (state == ST_START) ||
                            (state == ST_TX) || (state == ST_LINE_ACK);

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            timer        <= '0;
            retry        <= '0;
            bit_cnt      <= '0;
            tx_byte      <= '0;
            arg_byte     <= '0;
            arg_pending  <= 1'b0;
            ps2_c_oe     <= 1'b0;
            ps2_d_oe     <= 1'b0;
            cmd.done     <= 1'b0;
            cmd.err      <= 1'b0;
            cmd.err_code <= ERR_NONE;
        end else begin
            cmd.done <= 1'b0;
            cmd.err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        tx_byte      <= cmd.cmd_byte;
                        arg_byte     <= cmd.cmd_arg;
                        arg_pending  <= cmd.cmd_has_arg;
                        retry        <= '0;
                        cmd.err_code <= ERR_NONE;
                        ps2_c_oe     <= 1'b1;
                        timer        <= INH_LOAD;
                        state        <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (timer == '0) begin
                        ps2_c_oe <= 1'b0;
                        ps2_d_oe <= 1'b1;
                        state    <= ST_START;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_START: begin
                    bit_cnt <= '0;
                    timer   <= BIT_LOAD;
                    state   <= ST_TX;
                end
                ST_TX: begin
                    // Stop bit is a 1, so the tenth fall releases the data line.
                    if (c_fall) begin
                        ps2_d_oe <= ~frame[bit_cnt];
                        timer    <= BIT_LOAD;
                        if (bit_cnt == 4'd9) state <= ST_LINE_ACK;
                        else bit_cnt <= bit_cnt + 1'b1;
                    end else if (timer == '0) begin
                        ps2_d_oe     <= 1'b0;
                        cmd.err      <= 1'b1;
                        cmd.err_code <= ERR_BIT_TIMEOUT;
                        state        <= ST_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_LINE_ACK: begin
                    if (c_fall) begin
                        if (!d_level) begin
                            timer <= ACK_LOAD;
                            state <= ST_ACK_WAIT;
                        end else begin
                            ps2_d_oe     <= 1'b0;
                            cmd.err      <= 1'b1;
                            cmd.err_code <= ERR_NO_LINE_ACK;
                            state        <= ST_IDLE;
                        end
                    end else if (timer == '0) begin
                        ps2_d_oe     <= 1'b0;
                        cmd.err      <= 1'b1;
                        cmd.err_code <= ERR_BIT_TIMEOUT;
                        state        <= ST_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_ACK_WAIT: begin
                    // Any received byte takes priority over a same-cycle expiry.
                    if (rx_valid) begin
                        if (rx_byte == PS2_ACK) begin
                            if (arg_pending) begin
                                tx_byte     <= arg_byte;
                                arg_pending <= 1'b0;
                                retry       <= '0;
                                ps2_c_oe    <= 1'b1;
                                timer       <= INH_LOAD;
                                state       <= ST_INHIBIT;
                            end else begin
                                cmd.done <= 1'b1;
                                state    <= ST_IDLE;
                            end
                        end else if (rx_byte == PS2_RESEND) begin
                            if (32'(retry) < MAX_RETRY) begin
                                retry    <= retry + 1'b1;
                                ps2_c_oe <= 1'b1;
                                timer    <= INH_LOAD;
                                state    <= ST_INHIBIT;
                            end else begin
                                cmd.err      <= 1'b1;
                                cmd.err_code <= ERR_NO_ACK;
                                state        <= ST_IDLE;
                            end
                        end
                    end else if (timer == '0) begin
                        cmd.err      <= 1'b1;
                        cmd.err_code <= ERR_NO_ACK;
                        state        <= ST_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    ps2_c_oe <= 1'b0;
                    ps2_d_oe <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Directed bench for ps2_host_ctrl: a behavioural keyboard drives the shared
// open-drain lines and replies with ACK/RESEND bytes on the receiver path.
module tb_ps2_host_ctrl;
    import ps2_pkg::*;

    localparam int INH    = 40;
    localparam int BIT_TO = 400;
    localparam int ACK_TO = 3000;
    localparam int MAXR   = 2;
    localparam int H      = 20;

    logic       clk_100mhz = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_c, ps2_d, ps2_c_oe, ps2_d_oe;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       host_tx_active;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    ps2_state_e state_dbg;

    int n_assert = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int err_cyc = 0;
    int fall4_cyc = 0;

    ps2_host_ctrl_if cmd ();

    ps2_host_ctrl #(
        .INHIBIT_CYC (INH), .BIT_TIMEOUT_CYC (BIT_TO),
        .ACK_TIMEOUT_CYC (ACK_TO), .MAX_RETRY (MAXR)
    ) dut (
        .clk_100mhz (clk_100mhz), .rst_n (rst_n),
        .ps2_c (ps2_c), .ps2_d (ps2_d),
        .ps2_c_oe (ps2_c_oe), .ps2_d_oe (ps2_d_oe),
        .rx_valid (rx_valid), .rx_byte (rx_byte),
        .host_tx_active (host_tx_active),
        .cmd (cmd.slave), .state_dbg (state_dbg)
    );

    // Clock / reset / open-drain bus
    always #5 clk_100mhz = ~clk_100mhz;
    assign ps2_c = ~(ps2_c_oe | dev_c_low);
    assign ps2_d = ~(ps2_d_oe | dev_d_low);

    always @(posedge clk_100mhz) cyc++;

    always @(negedge clk_100mhz) begin
        if (cmd.done) done_cnt++;
        if (cmd.err) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 5 ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic send_cmd(input logic [7:0] b, input logic has_arg, input logic [7:0] a);
        cmd.cmd_byte    = b;
        cmd.cmd_has_arg = has_arg;
        cmd.cmd_arg     = a;
        cmd.cmd_valid   = 1'b1;
        @(negedge clk_100mhz);
        cmd.cmd_valid   = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk_100mhz);
        rx_valid = 1'b0;
    endtask

    // Keyboard side of one host-to-device frame; stops clocking after stop_after falls.
    task automatic dev_frame(input bit do_ack, input int stop_after,
                             output logic [9:0] bits, output int inh_len);
        int n;
        bits    = '0;
        inh_len = 0;
        n       = 0;
        while (!ps2_c_oe && n < 5000) begin
            @(negedge clk_100mhz);
            n++;
        end
        check("inhibit_seen", 32'(ps2_c_oe), 32'd1);
        check("tx_active_in_inhibit", 32'(host_tx_active), 32'd1);
        while (ps2_c_oe && inh_len < 5000) begin
            inh_len++;
            @(negedge clk_100mhz);
        end
        check("start_bit_driven", 32'(ps2_d_oe), 32'd1);
        repeat (10) @(negedge clk_100mhz);
        for (int k = 1; k <= 11; k++) begin
            if (k > stop_after) return;
            if (k == 11 && do_ack) begin
                dev_d_low = 1'b1;
                repeat (H / 2) @(negedge clk_100mhz);
            end
            dev_c_low = 1'b1;
            if (k == 4) fall4_cyc = cyc;
            repeat (H - 1) @(negedge clk_100mhz);
            if (k <= 10) bits[k-1] = ps2_d;
            @(negedge clk_100mhz);
            dev_c_low = 1'b0;
            repeat (H) @(negedge clk_100mhz);
        end
        dev_d_low = 1'b0;
    endtask

    logic [9:0] bits;
    int         inh;
    int         w;
    int         done_before;
    int         err_before;

    initial begin
        cmd.cmd_valid   = 1'b0;
        cmd.cmd_byte    = 8'h00;
        cmd.cmd_has_arg = 1'b0;
        cmd.cmd_arg     = 8'h00;
        repeat (3) @(negedge clk_100mhz);

        // Reset values
        check("rst_c_oe", 32'(ps2_c_oe), 32'd0);
        check("rst_d_oe", 32'(ps2_d_oe), 32'd0);
        check("rst_cmd_ready", 32'(cmd.cmd_ready), 32'd1);
        check("rst_busy", 32'(cmd.busy), 32'd0);
        check("rst_tx_active", 32'(host_tx_active), 32'd0);
        check("rst_done", 32'(cmd.done), 32'd0);
        check("rst_err", 32'(cmd.err), 32'd0);
        check("rst_err_code", 32'(cmd.err_code), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk_100mhz);

        // 0xF4, no argument: 0xF4 has five ones, so odd parity is 0
        send_cmd(8'hF4, 1'b0, 8'h00);
        dev_frame(1'b1, 11, bits, inh);
        check("f4_inhibit_len", 32'(inh), INH);
        check("f4_data", 32'(bits[7:0]), 32'hF4);
        check("f4_parity", 32'(bits[8]), 32'd0);
        check("f4_stop", 32'(bits[9]), 32'd1);
        check("f4_ackwait_tx_active", 32'(host_tx_active), 32'd0);
        check("f4_busy_before_ack", 32'(cmd.busy), 32'd1);
        send_rx(PS2_ACK);
        repeat (5) @(negedge clk_100mhz);
        check("f4_done_cnt", 32'(done_cnt), 32'd1);
        check("f4_busy_after", 32'(cmd.busy), 32'd0);
        check("f4_ready_after", 32'(cmd.cmd_ready), 32'd1);
        check("f4_err_cnt", 32'(err_cnt), 32'd0);

        // 0xED + 0x02: 0xED has six ones (parity 1), 0x02 has one (parity 0)
        send_cmd(PS2_SET_LED, 1'b1, 8'h02);
        dev_frame(1'b1, 11, bits, inh);
        check("ed_inhibit_len", 32'(inh), INH);
        check("ed_data", 32'(bits[7:0]), 32'hED);
        check("ed_parity", 32'(bits[8]), 32'd1);
        send_rx(PS2_ACK);
        check("ed_no_done_yet", 32'(done_cnt), 32'd1);
        check("ed_busy_between", 32'(cmd.busy), 32'd1);
        dev_frame(1'b1, 11, bits, inh);
        check("arg_inhibit_len", 32'(inh), INH);
        check("arg_data", 32'(bits[7:0]), 32'h02);
        check("arg_parity", 32'(bits[8]), 32'd0);
        check("arg_stop", 32'(bits[9]), 32'd1);
        send_rx(PS2_ACK);
        repeat (5) @(negedge clk_100mhz);
        check("ed_done_cnt", 32'(done_cnt), 32'd2);

        // 0xFF with two resends then ACK
        send_cmd(8'hFF, 1'b0, 8'h00);
        for (int t = 0; t < 3; t++) begin
            dev_frame(1'b1, 11, bits, inh);
            check("retry_data", 32'(bits[7:0]), 32'hFF);
            check("retry_parity", 32'(bits[8]), 32'd1);
            check("retry_inhibit_len", 32'(inh), INH);
            if (t < 2) send_rx(PS2_RESEND);
            else send_rx(PS2_ACK);
        end
        repeat (5) @(negedge clk_100mhz);
        check("retry_done_cnt", 32'(done_cnt), 32'd3);
        check("retry_err_cnt", 32'(err_cnt), 32'd0);

        // 0xFF with three resends: retries exhausted
        send_cmd(8'hFF, 1'b0, 8'h00);
        for (int t = 0; t < 3; t++) begin
            dev_frame(1'b1, 11, bits, inh);
            check("exhaust_data", 32'(bits[7:0]), 32'hFF);
            send_rx(PS2_RESEND);
        end
        repeat (5) @(negedge clk_100mhz);
        check("exhaust_err_cnt", 32'(err_cnt), 32'd1);
        check("exhaust_err_code", 32'(cmd.err_code), 32'(ERR_NO_ACK));
        check("exhaust_busy", 32'(cmd.busy), 32'd0);
        check("exhaust_done_cnt", 32'(done_cnt), 32'd3);

        // Device stops clocking after fall 4
        send_cmd(8'hF4, 1'b0, 8'h00);
        check("err_code_cleared", 32'(cmd.err_code), 32'(ERR_NONE));
        dev_frame(1'b1, 4, bits, inh);
        w = 0;
        while (err_cnt < 2 && w < BIT_TO + 200) begin
            @(negedge clk_100mhz);
            w++;
        end
        check("bitto_err_cnt", 32'(err_cnt), 32'd2);
        check("bitto_latency_in_window",
              32'((err_cyc - fall4_cyc >= BIT_TO) && (err_cyc - fall4_cyc <= BIT_TO + 10)), 32'd1);
        check("bitto_err_code", 32'(cmd.err_code), 32'(ERR_BIT_TIMEOUT));
        check("bitto_c_oe", 32'(ps2_c_oe), 32'd0);
        check("bitto_d_oe", 32'(ps2_d_oe), 32'd0);
        repeat (10) @(negedge clk_100mhz);

        // No line-ack at fall 11
        send_cmd(8'hF4, 1'b0, 8'h00);
        dev_frame(1'b0, 11, bits, inh);
        repeat (5) @(negedge clk_100mhz);
        check("nolack_err_cnt", 32'(err_cnt), 32'd3);
        check("nolack_err_code", 32'(cmd.err_code), 32'(ERR_NO_LINE_ACK));
        check("nolack_d_oe", 32'(ps2_d_oe), 32'd0);
        check("nolack_busy", 32'(cmd.busy), 32'd0);

        // Unrelated scancode during ACK_WAIT is ignored
        send_cmd(8'hF4, 1'b0, 8'h00);
        dev_frame(1'b1, 11, bits, inh);
        send_rx(8'h1C);
        repeat (5) @(negedge clk_100mhz);
        check("scan_still_busy", 32'(cmd.busy), 32'd1);
        check("scan_no_done", 32'(done_cnt), 32'd3);
        send_rx(PS2_ACK);
        repeat (5) @(negedge clk_100mhz);
        check("scan_done_cnt", 32'(done_cnt), 32'd4);
        check("scan_err_cnt", 32'(err_cnt), 32'd3);

        // No ACK byte at all
        send_cmd(8'hF4, 1'b0, 8'h00);
        dev_frame(1'b1, 11, bits, inh);
        w = 0;
        while (err_cnt < 4 && w < ACK_TO + 200) begin
            @(negedge clk_100mhz);
            w++;
        end
        check("ackto_err_cnt", 32'(err_cnt), 32'd4);
        check("ackto_err_code", 32'(cmd.err_code), 32'(ERR_NO_ACK));
        repeat (10) @(negedge clk_100mhz);

        // Reset in the middle of TX: fall 4 drives ~bit3 of 0xF4 = 1
        done_before = done_cnt;
        err_before  = err_cnt;
        send_cmd(8'hF4, 1'b0, 8'h00);
        dev_frame(1'b1, 4, bits, inh);
        check("midtx_d_oe_before", 32'(ps2_d_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midtx_d_oe_async", 32'(ps2_d_oe), 32'd0);
        check("midtx_c_oe_async", 32'(ps2_c_oe), 32'd0);
        repeat (3) @(negedge clk_100mhz);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_100mhz);
        check("midtx_ready", 32'(cmd.cmd_ready), 32'd1);
        check("midtx_state", 32'(state_dbg), 32'(ST_IDLE));
        repeat (BIT_TO + 50) @(negedge clk_100mhz);
        check("midtx_no_done", 32'(done_cnt), 32'(done_before));
        check("midtx_no_err", 32'(err_cnt), 32'(err_before));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
